// File: rtl/imap_stream_biu_if.sv
// Bus bundle between the imap BIU and its surroundings: control, arbiter read port and imap SRAM write port.
// The master modport is the BIU's view; slave is the view of the controller/arbiter/SRAM side.
interface imap_stream_biu_if #(
  parameter int BUS_DW = 32,
  parameter int PACK   = 2,
  parameter int CNT_W  = 16
);
  logic                     imap_start;
  logic                     imap_abort;
  logic [31:0]              imap_base_addr;
  logic [CNT_W-1:0]         imap_len_words;
  logic                     imap_busy;
  logic                     imap_done;
  logic                     req_vld;
  logic [31:0]              req_addr;
  logic                     req_rdy;
  logic                     rsp_vld;
  logic [BUS_DW-1:0]        rsp_data;
  logic                     rsp_rdy;
  logic [31:0]              imap_waddr;
  logic [PACK*BUS_DW-1:0]   imap_wdata;
  logic                     imap_wen;
  logic                     imap_wrdy;

  modport master (
    input  imap_start, imap_abort, imap_base_addr, imap_len_words,
    input  req_rdy, rsp_vld, rsp_data, imap_wrdy,
    output imap_busy, imap_done, req_vld, req_addr, rsp_rdy,
    output imap_waddr, imap_wdata, imap_wen
  );

  modport slave (
    output imap_start, imap_abort, imap_base_addr, imap_len_words,
    output req_rdy, rsp_vld, rsp_data, imap_wrdy,
    input  imap_busy, imap_done, req_vld, req_addr, rsp_rdy,
    input  imap_waddr, imap_wdata, imap_wen
  );
endinterface

// File: rtl/imap_stream_biu.sv
// Input-feature-map BIU: issues up to MAX_OUTSTD reads, packs PACK beats per SRAM word and
// writes the words round-robin across NBANK imap buffer banks.
module imap_stream_biu #(
  parameter int BUS_DW     = 32,
  parameter int PACK       = 2,
  parameter int NBANK      = 4,
  parameter int BANK_DEPTH = 3136,
  parameter int MAX_OUTSTD = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  imap_stream_biu_if.master bus
);

  localparam int          OW        = $clog2(MAX_OUTSTD + 1);
  localparam int          LW        = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int          BW        = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int          WW        = PACK * BUS_DW;
  localparam logic [31:0] ADDR_STEP = 32'(BUS_DW / 8);
  localparam logic [31:0] BANK_STEP = 32'(BANK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_rcnt;
  logic [OW-1:0]    r_outstd;
  logic [31:0]      r_addr;
  logic [LW-1:0]    r_lane;
  logic [BW-1:0]    r_bank;
  logic [31:0]      r_bank_base;
  logic [31:0]      r_row;
  logic [WW-1:0]    r_pack;

  logic             w_run;
  logic             w_drain;
  logic             w_start;
  logic             w_req_vld;
  logic             w_req_hs;
  logic             w_last_beat;
  logic             w_close;
  logic             w_rsp_rdy;
  logic             w_rsp_hs;
  logic             w_wen;
  logic [WW-1:0]    w_wdata;

  assign w_run       = (r_state == S_RUN);
  assign w_drain     = (r_state == S_DRAIN);
  assign w_start     = (r_state == S_IDLE) & bus.imap_start;

  // Abort cuts request issue in the very cycle it is seen, before the state moves to DRAIN.
  assign w_req_vld   = w_run & ~bus.imap_abort & (r_issued < r_len) &
                       (r_outstd < OW'(MAX_OUTSTD));
  assign w_req_hs    = w_req_vld & bus.req_rdy;

  assign w_last_beat = (r_rcnt == (r_len - CNT_W'(1)));
  assign w_close     = (r_lane == LW'(PACK - 1)) | w_last_beat;
  assign w_rsp_rdy   = w_drain | (w_run & (~w_close | bus.imap_wrdy));
  assign w_rsp_hs    = bus.rsp_vld & w_rsp_rdy;
  assign w_wen       = w_run & w_rsp_hs & w_close;

  // Lane 0 sits in the MSBs; lanes past the current beat stay zero for a short final word.
  always_comb begin
    w_wdata = '0;
    for (int l = 0; l < PACK; l++) begin
      if (LW'(l) < r_lane) begin
        w_wdata[(PACK-1-l)*BUS_DW +: BUS_DW] = r_pack[(PACK-1-l)*BUS_DW +: BUS_DW];
      end else if (LW'(l) == r_lane) begin
        w_wdata[(PACK-1-l)*BUS_DW +: BUS_DW] = bus.rsp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.imap_start) begin
          w_next = (bus.imap_len_words == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_wen & w_last_beat) begin
          w_next = S_DONE;
        end else if (bus.imap_abort) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_outstd == '0) begin
          w_next = S_IDLE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request side: issue counter, running byte address and in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len    <= '0;
      r_issued <= '0;
      r_addr   <= '0;
      r_outstd <= '0;
    end else if (w_start) begin
      r_len    <= bus.imap_len_words;
      r_issued <= '0;
      r_addr   <= bus.imap_base_addr;
      r_outstd <= '0;
    end else begin
      if (w_req_hs) begin
        r_issued <= r_issued + CNT_W'(1);
        r_addr   <= r_addr + ADDR_STEP;
      end
      if (w_req_hs & ~w_rsp_hs) begin
        r_outstd <= r_outstd + OW'(1);
      end else if (~w_req_hs & w_rsp_hs & (r_outstd != '0)) begin
        r_outstd <= r_outstd - OW'(1);
      end
    end
  end

  // Response side: beat/lane tracking, pack register and bank/row walk of the write address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt      <= '0;
      r_lane      <= '0;
      r_pack      <= '0;
      r_bank      <= '0;
      r_bank_base <= '0;
      r_row       <= '0;
    end else if (w_start) begin
      r_rcnt      <= '0;
      r_lane      <= '0;
      r_pack      <= '0;
      r_bank      <= '0;
      r_bank_base <= '0;
      r_row       <= '0;
    end else if (w_run & w_rsp_hs) begin
      r_rcnt <= r_rcnt + CNT_W'(1);
      if (w_close) begin
        r_lane <= '0;
        r_pack <= '0;
        if (r_bank == BW'(NBANK - 1)) begin
          r_bank      <= '0;
          r_bank_base <= '0;
          r_row       <= r_row + 32'd1;
        end else begin
          r_bank      <= r_bank + BW'(1);
          r_bank_base <= r_bank_base + BANK_STEP;
        end
      end else begin
        r_lane <= r_lane + LW'(1);
        r_pack <= w_wdata;
      end
    end
  end

  assign bus.imap_busy  = (r_state != S_IDLE);
  assign bus.imap_done  = (r_state == S_DONE);
  assign bus.req_vld    = w_req_vld;
  assign bus.req_addr   = r_addr;
  assign bus.rsp_rdy    = w_rsp_rdy;
  assign bus.imap_waddr = r_bank_base + r_row;
  assign bus.imap_wdata = w_wdata;
  assign bus.imap_wen   = w_wen;

endmodule
